// File: rtl/ay_pkg.sv
// ay_pkg: shared constants for the AY-3-8910 (Capcom flavour) PSG model.
//   - register address map R0..R15
//   - envelope shape bit positions inside R13
//   - sound-tick prescaler ratios for tone and noise/envelope
//   - reg_mask(): per-register storage width, applied on CPU data writes
package ay_pkg;

    localparam logic [3:0] R_TONE_A_L  = 4'd0;
    localparam logic [3:0] R_TONE_A_H  = 4'd1;
    localparam logic [3:0] R_TONE_B_L  = 4'd2;
    localparam logic [3:0] R_TONE_B_H  = 4'd3;
    localparam logic [3:0] R_TONE_C_L  = 4'd4;
    localparam logic [3:0] R_TONE_C_H  = 4'd5;
    localparam logic [3:0] R_NOISE_PER = 4'd6;
    localparam logic [3:0] R_MIXER     = 4'd7;
    localparam logic [3:0] R_AMP_A     = 4'd8;
    localparam logic [3:0] R_AMP_B     = 4'd9;
    localparam logic [3:0] R_AMP_C     = 4'd10;
    localparam logic [3:0] R_ENV_L     = 4'd11;
    localparam logic [3:0] R_ENV_H     = 4'd12;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;
    localparam logic [3:0] R_IO_A      = 4'd14;
    localparam logic [3:0] R_IO_B      = 4'd15;

    // Envelope shape bits in R13
    localparam int ENV_HOLD = 0;
    localparam int ENV_ALT  = 1;
    localparam int ENV_ATT  = 2;
    localparam int ENV_CONT = 3;

    // Amplitude register bit that selects the envelope as level source
    localparam int AMP_ENV_BIT = 4;

    // Sound ticks per tone tick and per noise/envelope tick
    localparam int TONE_PRESC = 8;
    localparam int NE_PRESC   = 16;

    localparam int TP_W = 12;

    function automatic logic [7:0] reg_mask(input logic [3:0] r);
        case (r)
            R_TONE_A_H, R_TONE_B_H, R_TONE_C_H, R_ENV_SHAPE: return 8'h0F;
            R_NOISE_PER, R_AMP_A, R_AMP_B, R_AMP_C:          return 8'h1F;
            default:                                         return 8'hFF;
        endcase
    endfunction

    // One channel of the mixer: gate from tone/noise enables, then level select.
    function automatic logic [3:0] mix_level(input logic       tone,
                                             input logic       noise,
                                             input logic       tone_off,
                                             input logic       noise_off,
                                             input logic [4:0] amp,
                                             input logic [3:0] env);
        logic       gate;
        logic [3:0] lvl;
        gate = (tone | tone_off) & (noise | noise_off);
        lvl  = amp[AMP_ENV_BIT] ? env : amp[3:0];
        return gate ? lvl : 4'h0;
    endfunction

endpackage

// File: rtl/ay_tone_gen.sv
// ay_tone_gen: one square-wave tone channel.
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   i_tick    tone tick (one clk wide)
//   i_period  12-bit tone period; 0 behaves as 1
//   o_tone    square-wave output, toggles every max(period,1) tone ticks
module ay_tone_gen
    import ay_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_tick,
    input  logic [TP_W-1:0] i_period,
    output logic            o_tone
);

    logic [TP_W-1:0] r_cnt;
    logic            r_tone;
    logic [TP_W:0]   w_cnt_nxt;
    logic [TP_W:0]   w_per_eff;

    assign w_cnt_nxt = {1'b0, r_cnt} + 1'b1;
    assign w_per_eff = (i_period == '0) ? {{TP_W{1'b0}}, 1'b1} : {1'b0, i_period};

    // The counter is never cleared by a period write; a shorter period simply
    // trips the >= compare on the next tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (i_tick) begin
            if (w_cnt_nxt >= w_per_eff) begin
                r_cnt  <= '0;
                r_tone <= ~r_tone;
            end else begin
                r_cnt  <= w_cnt_nxt[TP_W-1:0];
            end
        end
    end

    assign o_tone = r_tone;

endmodule

// File: rtl/ay_3_8910_capcom.sv
// ay_3_8910_capcom: AY-3-8910 programmable sound generator core.
//   clk        system clock, all logic on rising edge
//   reset_n    asynchronous active-low reset
//   sound_clk  PSG timebase level; each rising edge is one sound tick
//   din        CPU write data
//   adr        0 = address latch, 1 = data register
//   wr_n       write strobe, active-low
//   cs_n       chip select, active-low
//   A, B, C    registered 4-bit channel amplitudes
// Parameters: dump_regs (1 = trace register writes), id (chip index in trace).
// Optional macro AY_REG_TRACE_EN compiles the register-write trace; without it
// no trace logic exists and dump_regs is ignored.
module ay_3_8910_capcom
    import ay_pkg::*;
#(
    parameter int dump_regs = 0,
    parameter int id        = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sound_clk,
    input  logic [7:0] din,
    input  logic       adr,
    input  logic       wr_n,
    input  logic       cs_n,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] C
);

    // sound_clk is asynchronous to clk: two-flop synchroniser, then edge detect
    logic r_snd_meta, r_snd_sync, r_snd_prev;
    logic w_snd_tick;
    // CPU write edge detector and register file
    logic       r_wr_q;
    logic       w_wr_act, w_wr_ev;
    logic [3:0] r_addr;
    logic [7:0] r_regs [16];
    // prescaler and derived ticks
    logic [3:0] r_presc;
    logic       w_tone_tick, w_ne_tick;
    // tone / noise / envelope
    logic [2:0]  w_tone;
    logic [4:0]  r_noise_cnt;
    logic [5:0]  w_noise_cnt_nxt, w_np_eff;
    logic [16:0] r_lfsr;
    logic [15:0] r_env_cnt;
    logic [16:0] w_env_cnt_nxt, w_ep_eff;
    logic        w_env_step, w_wr_shape;
    logic [3:0]  r_step, r_hold_val, w_env_val, w_shape;
    logic        r_att, r_hold;
    logic        w_unused_bits;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snd_meta <= 1'b0;
            r_snd_sync <= 1'b0;
            r_snd_prev <= 1'b0;
        end else begin
            r_snd_meta <= sound_clk;
            r_snd_sync <= r_snd_meta;
            r_snd_prev <= r_snd_sync;
        end
    end
    assign w_snd_tick = r_snd_sync & ~r_snd_prev;

    // A strobe held low for many clocks is one write only.
    assign w_wr_act   = ~cs_n & ~wr_n;
    assign w_wr_ev    = w_wr_act & ~r_wr_q;
    assign w_wr_shape = w_wr_ev & adr & (r_addr == R_ENV_SHAPE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_q <= 1'b0;
            r_addr <= '0;
            for (int i = 0; i < 16; i++) r_regs[i] <= 8'h00;
        end else begin
            r_wr_q <= w_wr_act;
            if (w_wr_ev) begin
                if (!adr) begin
                    // Address writes with a non-zero upper nibble select another chip
                    if (din[7:4] == 4'h0) r_addr <= din[3:0];
                end else begin
                    r_regs[r_addr] <= din & reg_mask(r_addr);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_presc <= '0;
        else if (w_snd_tick) r_presc <= r_presc + 4'd1;
    end
    assign w_tone_tick = w_snd_tick && (r_presc[2:0] == 3'(TONE_PRESC - 1));
    assign w_ne_tick   = w_snd_tick && (r_presc == 4'(NE_PRESC - 1));

    ay_tone_gen u_tone_a (
        .i_clk(clk), .i_rst_n(reset_n), .i_tick(w_tone_tick),
        .i_period({r_regs[R_TONE_A_H][3:0], r_regs[R_TONE_A_L]}), .o_tone(w_tone[0])
    );
    ay_tone_gen u_tone_b (
        .i_clk(clk), .i_rst_n(reset_n), .i_tick(w_tone_tick),
        .i_period({r_regs[R_TONE_B_H][3:0], r_regs[R_TONE_B_L]}), .o_tone(w_tone[1])
    );
    ay_tone_gen u_tone_c (
        .i_clk(clk), .i_rst_n(reset_n), .i_tick(w_tone_tick),
        .i_period({r_regs[R_TONE_C_H][3:0], r_regs[R_TONE_C_L]}), .o_tone(w_tone[2])
    );

    // Noise: 17-bit LFSR, feedback bit0^bit3 entering at bit16
    assign w_noise_cnt_nxt = {1'b0, r_noise_cnt} + 6'd1;
    assign w_np_eff = (r_regs[R_NOISE_PER][4:0] == 5'd0) ? 6'd1
                                                          : {1'b0, r_regs[R_NOISE_PER][4:0]};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_noise_cnt <= '0;
            r_lfsr      <= 17'd1;
        end else if (w_ne_tick) begin
            if (w_noise_cnt_nxt >= w_np_eff) begin
                r_noise_cnt <= '0;
                r_lfsr      <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[16:1]};
            end else begin
                r_noise_cnt <= w_noise_cnt_nxt[4:0];
            end
        end
    end

    // Envelope
    assign w_shape       = r_regs[R_ENV_SHAPE][3:0];
    assign w_env_cnt_nxt = {1'b0, r_env_cnt} + 17'd1;
    assign w_ep_eff      = ({r_regs[R_ENV_H], r_regs[R_ENV_L]} == 16'd0) ? 17'd1
                           : {1'b0, r_regs[R_ENV_H], r_regs[R_ENV_L]};
    assign w_env_step    = w_ne_tick && (w_env_cnt_nxt >= w_ep_eff);
    assign w_env_val     = r_hold ? r_hold_val : (r_att ? r_step : ~r_step);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_env_cnt  <= '0;
            r_step     <= '0;
            r_att      <= 1'b0;
            r_hold     <= 1'b0;
            r_hold_val <= '0;
        end else begin
            if (w_ne_tick) begin
                r_env_cnt <= w_env_step ? 16'd0 : w_env_cnt_nxt[15:0];
            end
            // A shape write restarts the envelope and wins over a same-cycle step
            if (w_wr_shape) begin
                r_step <= '0;
                r_hold <= 1'b0;
                r_att  <= din[ENV_ATT];
            end else if (w_env_step && !r_hold) begin
                if (r_step != 4'hF) begin
                    r_step <= r_step + 4'd1;
                end else if (!w_shape[ENV_CONT]) begin
                    r_hold     <= 1'b1;
                    r_hold_val <= 4'h0;
                end else if (w_shape[ENV_HOLD]) begin
                    r_hold     <= 1'b1;
                    r_hold_val <= {4{r_att}} ^ {4{w_shape[ENV_ALT]}};
                end else begin
                    r_step <= '0;
                    if (w_shape[ENV_ALT]) r_att <= ~r_att;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            A <= '0;
            B <= '0;
            C <= '0;
        end else begin
            A <= mix_level(w_tone[0], r_lfsr[0], r_regs[R_MIXER][0], r_regs[R_MIXER][3],
                           r_regs[R_AMP_A][4:0], w_env_val);
            B <= mix_level(w_tone[1], r_lfsr[0], r_regs[R_MIXER][1], r_regs[R_MIXER][4],
                           r_regs[R_AMP_B][4:0], w_env_val);
            C <= mix_level(w_tone[2], r_lfsr[0], r_regs[R_MIXER][2], r_regs[R_MIXER][5],
                           r_regs[R_AMP_C][4:0], w_env_val);
        end
    end

    // Bits that are stored but never drive sound (masked to zero or I/O ports)
    assign w_unused_bits = ^{r_regs[R_TONE_A_H][7:4], r_regs[R_TONE_B_H][7:4],
                             r_regs[R_TONE_C_H][7:4], r_regs[R_NOISE_PER][7:5],
                             r_regs[R_MIXER][7:6], r_regs[R_AMP_A][7:5],
                             r_regs[R_AMP_B][7:5], r_regs[R_AMP_C][7:5],
                             r_regs[R_ENV_SHAPE][7:4], r_regs[R_IO_A], r_regs[R_IO_B]};

`ifdef AY_REG_TRACE_EN
    always_ff @(posedge clk) begin
        if (dump_regs != 0 && w_wr_ev && adr) begin
            $display("AY%0d: R%0d <= %02h", id, r_addr, din & reg_mask(r_addr));
        end
    end
`else
    localparam int lp_unused_cfg = dump_regs + id;
`endif

endmodule

// File: tb/tb_ay_3_8910_capcom.sv
// tb_ay_3_8910_capcom: directed bench for ay_3_8910_capcom.
// sound_clk rises every 8 clk cycles, so 16 sound ticks = 128 clk cycles.
module tb_ay_3_8910_capcom;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sound_clk = 1'b0;
    logic [7:0] din = 8'h00;
    logic       adr = 1'b0;
    logic       wr_n = 1'b1;
    logic       cs_n = 1'b1;
    logic [3:0] A, B, C;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    // Toggles land on clk falling edges, away from the sampling edge
    initial forever #40 sound_clk = ~sound_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    ay_3_8910_capcom #(.dump_regs(0), .id(0)) dut (
        .clk(clk), .reset_n(reset_n), .sound_clk(sound_clk),
        .din(din), .adr(adr), .wr_n(wr_n), .cs_n(cs_n),
        .A(A), .B(B), .C(C)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wr(input logic a, input logic [7:0] d, input logic sel);
        @(negedge clk);
        adr  = a;
        din  = d;
        cs_n = ~sel;
        wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
        cs_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic reg_write(input logic [3:0] r, input logic [7:0] d);
        wr(1'b0, {4'h0, r}, 1'b1);
        wr(1'b1, d, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for A to change; reports new value and clk cycles taken.
    task automatic wait_a_change(input int budget, output logic [3:0] val,
                                 output int cyc, output bit to);
        logic [3:0] prev;
        prev = A;
        val  = A;
        cyc  = 0;
        to   = 1'b1;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (A !== prev) begin
                val = A;
                to  = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    logic [3:0]  v, pv;
    int          c;
    bit          to;
    logic [16:0] m;
    logic        fb;

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_C", C, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Tone: TA=2 -> 16 sound ticks (128 clk) per half period
        reg_write(4'd0, 8'h02);
        reg_write(4'd1, 8'h00);
        reg_write(4'd7, 8'h3E);
        reg_write(4'd8, 8'h0F);
        wait_a_change(400, v, c, to);
        check("tone_first_to", to, 0);
        check("tone_first_lvl", (v == 4'd0 || v == 4'd15), 1);
        pv = v;
        for (int i = 0; i < 4; i++) begin
            wait_a_change(400, v, c, to);
            check("tone_half_cyc", c, 128);
            check("tone_lvl", v, pv ^ 4'hF);
            check("tone_B", B, 0);
            check("tone_C", C, 0);
            pv = v;
        end

        // Period 0 behaves as 1: 8 sound ticks (64 clk)
        reg_write(4'd0, 8'h00);
        wait_a_change(400, v, c, to);
        for (int i = 0; i < 3; i++) begin
            wait_a_change(400, v, c, to);
            check("tone_p0_cyc", c, 64);
        end
        // High byte truncated to 4 bits: 0xF0 -> 0, so TA = 2 again
        reg_write(4'd1, 8'hF0);
        reg_write(4'd0, 8'h02);
        wait_a_change(400, v, c, to);
        for (int i = 0; i < 2; i++) begin
            wait_a_change(400, v, c, to);
            check("tone_trunc_cyc", c, 128);
        end

        // Reset mid-tone clears outputs immediately
        begin
            int k;
            k = 0;
            while (A !== 4'hF && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("pre_reset_lvl", A, 15);
        end
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_A", A, 0);
        check("async_rst_B", B, 0);
        check("async_rst_C", C, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_a_change(600, v, c, to);
        check("post_rst_silent_to", to, 1);
        check("post_rst_A", A, 0);
        check("post_rst_B", B, 0);
        check("post_rst_C", C, 0);

        // Address guard and chip select
        reg_write(4'd7, 8'h3F);
        wr(1'b0, 8'h08, 1'b1);
        wr(1'b0, 8'h18, 1'b1);
        wr(1'b1, 8'h0F, 1'b1);
        check("guard_A", A, 15);
        check("guard_B0", B, 0);
        wr(1'b0, 8'h09, 1'b1);
        wr(1'b0, 8'h18, 1'b1);
        wr(1'b1, 8'h0F, 1'b1);
        check("guard_B", B, 15);
        check("guard_C", C, 0);
        wr(1'b0, 8'h08, 1'b1);
        wr(1'b1, 8'h03, 1'b0);
        check("no_cs_A", A, 15);

        // Envelope single decay: 15..0 one step per 128 clk, then hold 0
        reg_write(4'd11, 8'h01);
        reg_write(4'd12, 8'h00);
        reg_write(4'd0, 8'h01);
        reg_write(4'd8, 8'h10);
        reg_write(4'd13, 8'h00);
        check("env_start", A, 15);
        for (int k = 1; k <= 15; k++) begin
            wait_a_change(400, v, c, to);
            check("env_dn_val", v, 15 - k);
            if (k > 1) check("env_dn_cyc", c, 128);
        end
        wait_a_change(1000, v, c, to);
        check("env_hold_to", to, 1);
        check("env_hold_A", A, 0);

        // Envelope triangle: 0..15, 15..0, 0..; end values last two steps
        reg_write(4'd13, 8'h0E);
        check("tri_start", A, 0);
        for (int k = 1; k <= 31; k++) begin
            wait_a_change(400, v, c, to);
            check("tri_val", v, (k <= 15) ? k : ((k <= 30) ? 30 - k : k - 30));
            if (k > 1) check("tri_cyc", c, (k == 16 || k == 31) ? 256 : 128);
        end

        // Long strobe is one write: the envelope keeps decaying during it
        wr(1'b0, 8'h0D, 1'b1);
        @(negedge clk);
        adr  = 1'b1;
        din  = 8'h00;
        cs_n = 1'b0;
        wr_n = 1'b0;
        repeat (400) @(negedge clk);
        wr_n = 1'b1;
        cs_n = 1'b1;
        check("long_strobe", (A <= 4'd12), 1);

        // Noise: LFSR from seed 1, one shift per 16 sound ticks
        do_reset();
        reg_write(4'd7, 8'h37);
        reg_write(4'd6, 8'h01);
        reg_write(4'd8, 8'h0F);
        check("noise_seed", A, 15);
        wait_a_change(300, v, c, to);
        check("noise_first_to", to, 0);
        check("noise_first_val", v, 0);
        check("noise_B", B, 0);
        m = 17'd1;
        fb = m[0] ^ m[3];
        m = (m >> 1) | ({16'd0, fb} << 16);
        repeat (64) @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            check("noise_bit", A, m[0] ? 15 : 0);
            fb = m[0] ^ m[3];
            m = (m >> 1) | ({16'd0, fb} << 16);
            repeat (128) @(negedge clk);
        end

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ay_3_8910_capcom.md
AY_3_8910_CAPCOM -- requirements
Module: ay_3_8910_capcom

Interface
REQ-001 SHALL have parameter dump_regs, default 0: 1 enables the register-write trace.
REQ-002 SHALL have parameter id, default 0: chip index printed in the trace.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 sound_clk  input  1  PSG timebase level; sampled in the clk domain, each rising edge is one sound tick.
REQ-006 din  input  8  CPU write data.
REQ-007 adr  input  1  0 = address latch, 1 = data register.
REQ-008 wr_n  input  1  write strobe, active-low.
REQ-009 cs_n  input  1  chip select, active-low.
REQ-010 A, B, C  output  4 each  channel amplitude, unsigned, registered.

Function
REQ-011 Write event: fires once per clk rising edge where cs_n=0 and wr_n=0, provided that condition was false on the previous edge; long strobes produce one event only.
REQ-012 adr=0 write:
- din[7:4]=0 -> latch din[3:0] as the register address.
- otherwise -> ignored.
REQ-013 adr=1 write stores din into the latched register, truncated to the register's width:
- R0/R1, R2/R3, R4/R5: 12-bit tone periods TA/TB/TC (low 8 bits + high 4 bits).
- R6: 5-bit noise period. R7: 8-bit mixer.
- R8–R10: 5-bit amplitudes; bit4 = envelope mode.
- R11/R12: 16-bit envelope period. R13: 4-bit shape. R14/R15: 8-bit stored, no effect.
REQ-014 Prescaler: tone tick every 8 sound ticks; noise and envelope tick every 16 sound ticks.
REQ-015 Tone:
- Per-channel counter increments on each tone tick.
- When counter ≥ period: tone output toggles and counter clears.
- Period 0 behaves as 1, so half-period = 8·max(TP,1) sound ticks.
REQ-016 Noise:
- 17-bit LFSR, seed 1; feedback = bit0 XOR bit3, shifted in at bit16.
- Shifts once per max(NP,1) noise ticks; noise output = bit0.
REQ-017 Mixer, per channel n (A=0, B=1, C=2): gate = (tone_n OR R7[n]) AND (noise OR R7[n+3]).
REQ-018 Level = amplitude bit4 ? envelope value : amplitude[3:0]. Output = gate ? level : 0, registered once per clk.
REQ-019 Envelope step:
- Step counter 0..15 advances every max(EP,1) envelope ticks.
- Value = ATT(R13[2]) ? step : 15−step.
REQ-020 Envelope end of each 16-step cycle:
- CONT(R13[3])=0 -> hold value 0.
- CONT=1 and HOLD(R13[0])=1 -> hold the final value, inverted if ALT(R13[1])=1.
- CONT=1, HOLD=0, ALT=1 -> reverse direction and continue.
- CONT=1, HOLD=0, ALT=0 -> restart at step 0.
REQ-021 Writing R13 restarts the envelope the same cycle: step=0, hold cleared, direction from ATT.
REQ-022 Simultaneous register write and tick: the tick uses the old value; the new value is effective on the next cycle.
REQ-023 Tone/noise/envelope counters are not reset by period writes; a period lowered below the count takes effect through the ≥ compare.

Reset
REQ-024 reset_n=0 SHALL clear, asynchronously:
- all registers R0–R15 and the address latch;
- all counters and the prescaler;
- tone outputs, envelope state, and the write edge detector.
REQ-025 During reset: A=B=C=0 and the LFSR is 1.

Configuration
REQ-026 With macro AY_REG_TRACE_EN defined and dump_regs=1: each data write SHALL $display id, register number and value.
REQ-027 Without AY_REG_TRACE_EN: no trace logic is compiled and dump_regs is ignored.

Structure
REQ-028 Package ay_pkg SHALL hold:
- register address constants R_TONE_A_L..R_IO_B;
- envelope shape bit positions;
- prescaler constants (8, 16).
REQ-029 One sub-module, ay_tone_gen (12-bit period counter plus toggle), SHALL be instantiated three times.

Verification
REQ-030 Reset: assert reset_n=0 mid-tone -> A=B=C=0 immediately; after release, all registers read back as 0 through behaviour (silent).
REQ-031 Tone: write R0=0x02, R1=0, R7=0x3E, R8=0x0F -> A alternates 15/0 with 16 sound ticks per half-period; B=C=0.
REQ-032 Address guard: adr=0 din=0x08, then adr=0 din=0x18, then data 0x0F -> R8 receives 0x0F. A write with cs_n=1 -> no change.
REQ-033 Envelope: R7=0x3E, R0=1, R8=0x10, R11=1, R12=0, R13=0x00 -> gated value steps 15..0, one step every 16 sound ticks, then holds 0.
REQ-034 Envelope repeat: R13=0x0E -> triangle 0..15..0, repeating without hold.
REQ-035 Noise: R7=0x37, R6=1, R8=0x0F -> A follows LFSR bit0 with the first bits from seed 1 per REQ-016, updating every 16 sound ticks.
